// File: rtl/cpu_pkg.sv
// Shared widths, ALU function codes, issue-FSM encoding and command record.
// Pure declarations: no latency, no flow control.
// Imported by the ALU issue controller and its register file.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_N  = 8;
    localparam int ADDR_W = 3;

    localparam logic [2:0] FN_PASS = 3'd0;
    localparam logic [2:0] FN_INC  = 3'd1;
    localparam logic [2:0] FN_DEC  = 3'd2;
    localparam logic [2:0] FN_ADD  = 3'd3;
    localparam logic [2:0] FN_NEG  = 3'd4;
    localparam logic [2:0] FN_OR   = 3'd5;
    localparam logic [2:0] FN_NOT  = 3'd6;
    localparam logic [2:0] FN_ILL  = 3'd7;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_READ = 2'd1;
    localparam state_t ST_EXEC = 2'd2;
    localparam state_t ST_WB   = 2'd3;

    typedef struct packed {
        logic [2:0]        op;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W-1:0] rd;
    } cmd_t;

    function automatic logic fn_legal(input logic [2:0] fn);
        return fn != FN_ILL;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// REG_N x DATA_W register file: one synchronous write port, two operand and one debug read port.
// Latency: write visible on reads the cycle after the write edge; reads are combinational.
// Backpressure: none, every write strobe is accepted.
module alu_regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [REG_N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one command at a time to an external combinational ALU and writes the result back.
// Latency: accept at edge N, operands at N+1, writeback at N+3; done high in the WB cycle.
// Backpressure: cmd_ready only in IDLE, so one command per 4 cycles.
module alu_issue_ctrl
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [2:0]        alu_fn,
    input  logic [DATA_W-1:0] alu_z,
    input  logic              alu_carry,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic              carry_flag,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state;
    state_t            state_nxt;
    cmd_t              cmd_q;
    logic              accept;
    logic              wb_legal;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rd_x;
    logic [DATA_W-1:0] rd_y;

    alu_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .ra_addr  (cmd_q.ra),
        .ra_data  (rd_x),
        .rb_addr  (cmd_q.rb),
        .rb_data  (rd_y),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Preload and writeback share the single write port; they live in disjoint states.
    always_comb begin
        cmd_ready = (state == ST_IDLE) && !rst;
        accept    = cmd_valid && cmd_ready;
        done      = (state == ST_WB);
        err       = (state == ST_WB) && !fn_legal(cmd_q.op);
        wb_legal  = (state == ST_WB) && fn_legal(cmd_q.op);
        rf_we     = 1'b0;
        rf_waddr  = ld_addr;
        rf_wdata  = ld_data;
        if (state == ST_IDLE && ld_en) begin
            rf_we = 1'b1;
        end else if (wb_legal) begin
            rf_we    = 1'b1;
            rf_waddr = cmd_q.rd;
            rf_wdata = alu_z;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= '0;
            alu_x      <= '0;
            alu_y      <= '0;
            alu_fn     <= FN_PASS;
            result     <= '0;
            carry_flag <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q.op <= cmd_op;
                cmd_q.ra <= cmd_ra;
                cmd_q.rb <= cmd_rb;
                cmd_q.rd <= cmd_rd;
            end
            // Operands are captured once here and then held through EXEC, WB and IDLE.
            if (state == ST_READ) begin
                alu_x  <= rd_x;
                alu_y  <= rd_y;
                alu_fn <= cmd_q.op;
            end
            if (wb_legal) begin
                result     <= alu_z;
                carry_flag <= alu_carry;
            end
        end
    end

endmodule
